jtframe_sdram64_arb: RTL and testbench
======================================

Name: jtframe_sdram64_arb

Overview:
- Shares the SDRAM command/address bus between four bank engines and the refresh engine.
- The refresh engine uses a br/bg handshake with an active-high `rfshing` ownership flag.
- Grants come from a single scheduler: refresh has priority, then round-robin among banks.
- The selected requester's command is muxed into one registered SDRAM command/address/bank output stage.
- Sits between the per-bank controllers / refresh engine and the SDRAM pins.

Parameters:
- BA_N, 4, number of bank requesters (fixed at 4; bank index is 2 bits).
- RFSH_WAIT, 1, idle cycles inserted after a refresh sequence ends before any bank grant.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  SDRAM clock
- rfsh_br  in  1  refresh bus request
- rfsh_bg  out  1  refresh bus grant pulse
- rfshing  in  1  refresh engine owns the bus while high
- rfsh_cmd  in  4  refresh command {/CS,/RAS,/CAS,/WE}
- rfsh_a  in  13  refresh address
- bank_br  in  4  per-bank request, held until granted
- bank_bg  out  4  per-bank grant pulse, one-hot
- bank_idle  in  4  bank has no burst in flight
- bank_cmd  in  16  packed commands, bank i at [4i+3:4i]
- bank_a  in  52  packed addresses, bank i at [13i+12:13i]
- sdram_cmd  out  4  registered command to pins
- sdram_a  out  13  registered address
- sdram_ba  out  2  registered bank address

Behaviour:
- Reset values:
  - FSM IDLE; rfsh_bg=0; bank_bg=0.
  - sdram_cmd=NOP (4'b0111); sdram_a=0; sdram_ba=0.
  - Round-robin pointer=0; wait counter=0.
- Command encoding: NOP=0111, PRECHARGE=0010, REFRESH=0001, ACTIVE=0011, READ=0101, WRITE=0100.
- FSM states and transitions:
  - IDLE, no pending refresh:
    - Pick the first bank with bank_br=1, scanning from the pointer upward mod 4.
    - Assert its bank_bg for exactly one cycle; go to BANK.
  - IDLE with rfsh_br=1:
    - Issue no bank grant.
    - If all bank_idle=1, pulse rfsh_bg one cycle and go to RFSH.
    - Otherwise hold in IDLE, which drains the banks.
  - BANK, one cycle:
    - sdram_cmd<=bank_cmd[g], sdram_a<=bank_a[g], sdram_ba<=g.
    - Pointer<=g+1 mod 4; return to IDLE.
    - Result: bank grants are separated by at least one cycle, and the bus issues at most one bank command every 2 cycles.
  - RFSH:
    - Register sdram_cmd<=rfsh_cmd, sdram_a<=rfsh_a, sdram_ba<=0 every cycle.
    - When a falling edge of rfshing has been seen (rfshing high at least once after the grant, then low), load the wait counter with RFSH_WAIT and go to WAIT.
  - WAIT: sdram_cmd=NOP; count down; at 0 go to IDLE.
  - All non-owned cycles: sdram_cmd=NOP; sdram_a and sdram_ba hold their last value.
- Simultaneous events:
  - rfsh_br and bank_br in the same IDLE cycle: refresh wins if all banks are idle; otherwise neither is granted and the bank waits.
  - A bank_br that drops before its grant is simply not granted.
  - A grant pulse never coincides with a dropped request sampled that same cycle; arbitration uses current inputs.
- RFSH watchdog: if rfshing never rises within 4 cycles of rfsh_bg, return to IDLE. This covers a refresh engine with nothing to do.
- Outputs are registered; grant-to-pin latency is 1 cycle.
- Reset mid-operation: the asynchronous return to the reset values above takes effect immediately, regardless of state.

Decomposition:
- Shared package jtframe_sdram64_pkg holds:
  - The CMD_* localparams (already duplicated across the sdram64 blocks).
  - State encodings IDLE/BANK/RFSH/WAIT.
- Sub-module jtframe_sdram64_rr4 is natural: a combinational round-robin picker taking (req[3:0], ptr[1:0]) and returning (valid, idx[1:0]).

Test Plan:
- Reset check: assert rst mid-BANK -> next edge sdram_cmd=0111, bank_bg=0, rfsh_bg=0.
- Round-robin fairness: bank_br=4'b1111 held, ptr=0 -> grants in order 0,1,2,3,0 on cycles 0,2,4,6,8; sdram_ba follows one cycle after each grant.
- Refresh blocked by busy banks: rfsh_br=1 with bank_idle=4'b1101 -> no grant of any kind. Set bank_idle=1111 -> rfsh_bg pulses the next cycle.
- Refresh pass-through: grant, then rfshing high 6 cycles with rfsh_cmd=0010 then 0001 -> the same sequence appears on sdram_cmd one cycle late. With RFSH_WAIT=1, one NOP follows before the next bank grant.
- Watchdog: rfsh_bg pulses and rfshing stays 0 -> FSM back in IDLE after 4 cycles; a pending bank_br=4'b0100 is granted bank 2.
- Address mux: bank_a[38:26]=13'h1ABC, bank_cmd[11:8]=0011, grant bank 2 -> sdram_a=1ABC, sdram_cmd=0011, sdram_ba=2.

Source files
------------

// File: rtl/jtframe_sdram64_pkg.sv
// Shared definitions for the sdram64 blocks.
//   CMD_*    : SDRAM command encodings {/CS,/RAS,/CAS,/WE}
//   arb_st_t : arbiter FSM states
//   WD_LAST  : last RFSH cycle index tolerated before rfshing must have risen
package jtframe_sdram64_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;

    // rfshing must rise within 4 cycles of rfsh_bg (cycle indices 0..3)
    localparam logic [1:0] WD_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BANK = 2'd1,
        ST_RFSH = 2'd2,
        ST_WAIT = 2'd3
    } arb_st_t;

endpackage

// File: rtl/jtframe_sdram64_rr4.sv
// Combinational 4-way round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index; scan goes ptr, ptr+1, ... mod 4
//   valid : at least one request present
//   idx   : selected requester
module jtframe_sdram64_rr4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    // Scan farthest offset first so the nearest one to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                valid = 1'b1;
                idx   = ptr + 2'(k);
            end
        end
    end

endmodule

// File: rtl/jtframe_sdram64_arb.sv
// SDRAM command bus arbiter for four bank engines plus the refresh engine.
// Refresh has priority (after the banks drain), banks are served round-robin.
// The owner's command/address is registered onto the pins one cycle after
// its grant pulse.
//   rst, clk              : async active-high reset, SDRAM clock
//   rfsh_br/rfsh_bg       : refresh request / one-cycle grant pulse
//   rfshing               : refresh engine owns the bus while high
//   rfsh_cmd/rfsh_a       : refresh command and address
//   bank_br/bank_bg       : per-bank request / one-hot grant pulse
//   bank_idle             : bank has no burst in flight
//   bank_cmd/bank_a       : packed per-bank command (4b) and address (13b)
//   sdram_cmd/_a/_ba      : registered pin outputs
module jtframe_sdram64_arb
    import jtframe_sdram64_pkg::*;
#(
    parameter int BA_N      = 4,
    parameter int RFSH_WAIT = 1
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 rfsh_br,
    output logic                 rfsh_bg,
    input  logic                 rfshing,
    input  logic [3:0]           rfsh_cmd,
    input  logic [12:0]          rfsh_a,
    input  logic [BA_N-1:0]      bank_br,
    output logic [BA_N-1:0]      bank_bg,
    input  logic [BA_N-1:0]      bank_idle,
    input  logic [4*BA_N-1:0]    bank_cmd,
    input  logic [13*BA_N-1:0]   bank_a,
    output logic [3:0]           sdram_cmd,
    output logic [12:0]          sdram_a,
    output logic [1:0]           sdram_ba
);

    arb_st_t         st, st_nx;
    logic [1:0]      ptr, ptr_nx;
    logic [1:0]      gsel, gsel_nx;     // bank granted, used in BANK
    logic [7:0]      cnt, cnt_nx;       // post-refresh hold-off
    logic [1:0]      wd, wd_nx;         // cycles in RFSH without rfshing
    logic            seen, seen_nx;     // rfshing has been high since grant
    logic [BA_N-1:0] bank_bg_nx;
    logic            rfsh_bg_nx;
    logic            rr_vld;
    logic [1:0]      rr_idx;
    logic [3:0]      sel_cmd;
    logic [12:0]     sel_a;

    jtframe_sdram64_rr4 u_rr (
        .req   (bank_br),
        .ptr   (ptr),
        .valid (rr_vld),
        .idx   (rr_idx)
    );

    always_comb begin
        sel_cmd = CMD_NOP;
        sel_a   = '0;
        for (int k = 0; k < BA_N; k++) begin
            if (gsel == 2'(k)) begin
                sel_cmd = bank_cmd[4*k +: 4];
                sel_a   = bank_a[13*k +: 13];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx      = st;
        ptr_nx     = ptr;
        gsel_nx    = gsel;
        cnt_nx     = cnt;
        wd_nx      = wd;
        seen_nx    = seen;
        bank_bg_nx = '0;
        rfsh_bg_nx = 1'b0;
        case (st)
            ST_IDLE: begin
                if (rfsh_br) begin
                    // Pending refresh blocks new bank grants so banks drain.
                    if (&bank_idle) begin
                        rfsh_bg_nx = 1'b1;
                        seen_nx    = 1'b0;
                        wd_nx      = '0;
                        st_nx      = ST_RFSH;
                    end
                end else if (rr_vld) begin
                    bank_bg_nx = BA_N'(1) << rr_idx;
                    gsel_nx    = rr_idx;
                    st_nx      = ST_BANK;
                end
            end
            ST_BANK: begin
                ptr_nx = gsel + 2'd1;
                st_nx  = ST_IDLE;
            end
            ST_RFSH: begin
                if (rfshing) begin
                    seen_nx = 1'b1;
                end else if (seen) begin
                    if (RFSH_WAIT == 0) begin
                        st_nx = ST_IDLE;
                    end else begin
                        cnt_nx = 8'(RFSH_WAIT);
                        st_nx  = ST_WAIT;
                    end
                end else if (wd == WD_LAST) begin
                    // Refresh engine never took the bus.
                    st_nx = ST_IDLE;
                end else begin
                    wd_nx = wd + 2'd1;
                end
            end
            ST_WAIT: begin
                // WAIT lasts RFSH_WAIT cycles.
                if (cnt <= 8'd1) st_nx = ST_IDLE;
                if (cnt != 8'd0) cnt_nx = cnt - 8'd1;
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            gsel      <= '0;
            cnt       <= '0;
            wd        <= '0;
            seen      <= 1'b0;
            bank_bg   <= '0;
            rfsh_bg   <= 1'b0;
            sdram_cmd <= CMD_NOP;
            sdram_a   <= '0;
            sdram_ba  <= '0;
        end else begin
            ptr     <= ptr_nx;
            gsel    <= gsel_nx;
            cnt     <= cnt_nx;
            wd      <= wd_nx;
            seen    <= seen_nx;
            bank_bg <= bank_bg_nx;
            rfsh_bg <= rfsh_bg_nx;
            case (st)
                ST_BANK: begin
                    sdram_cmd <= sel_cmd;
                    sdram_a   <= sel_a;
                    sdram_ba  <= gsel;
                end
                ST_RFSH: begin
                    sdram_cmd <= rfsh_cmd;
                    sdram_a   <= rfsh_a;
                    sdram_ba  <= '0;
                end
                default: sdram_cmd <= CMD_NOP;  // a/ba hold
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_sdram64_arb.sv
// Randomized bench for jtframe_sdram64_arb with a bus-ownership reference
// model and a small reactive refresh engine / bank request generator.
module tb_jtframe_sdram64_arb;

    localparam int RFSH_WAIT = 1;
    localparam logic [3:0] NOP = 4'b0111, PRE = 4'b0010, REF = 4'b0001;

    logic        rst = 1'b1, clk = 1'b0;
    logic        rfsh_br = 0, rfsh_bg, rfshing = 0;
    logic [3:0]  rfsh_cmd = NOP;
    logic [12:0] rfsh_a = '0;
    logic [3:0]  bank_br = '0, bank_bg, bank_idle = '1;
    logic [15:0] bank_cmd = '0;
    logic [51:0] bank_a = '0;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba;

    jtframe_sdram64_arb #(.BA_N(4), .RFSH_WAIT(RFSH_WAIT)) dut (
        .rst(rst), .clk(clk), .rfsh_br(rfsh_br), .rfsh_bg(rfsh_bg),
        .rfshing(rfshing), .rfsh_cmd(rfsh_cmd), .rfsh_a(rfsh_a),
        .bank_br(bank_br), .bank_bg(bank_bg), .bank_idle(bank_idle),
        .bank_cmd(bank_cmd), .bank_a(bank_a), .sdram_cmd(sdram_cmd),
        .sdram_a(sdram_a), .sdram_ba(sdram_ba)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: who owns the bus next ----------------
    int          m_pend;       // bank whose command goes to the pins next, -1 none
    int          m_ptr;        // bank with first claim in the next bank grant
    bit          m_rown;       // refresh engine owns the bus
    bit          m_rseen;
    int          m_rage;       // cycles spent owning refresh without rfshing
    int          m_hold;       // idle cycles still owed after a refresh
    logic [3:0]  e_bbg, e_cmd;
    logic        e_rbg;
    logic [12:0] e_a;
    logic [1:0]  e_ba;

    function automatic void model_reset();
        m_pend = -1; m_ptr = 0; m_rown = 0; m_rseen = 0; m_rage = 0; m_hold = 0;
        e_bbg = '0; e_rbg = 0; e_cmd = NOP; e_a = '0; e_ba = '0;
    endfunction

    // Expected outputs after the coming edge, from the inputs now applied.
    function automatic void model_step();
        bit found;
        e_bbg = '0; e_rbg = 0; e_cmd = NOP;
        if (m_pend >= 0) begin
            e_cmd  = bank_cmd[m_pend*4 +: 4];
            e_a    = bank_a[m_pend*13 +: 13];
            e_ba   = 2'(m_pend);
            m_ptr  = (m_pend + 1) % 4;
            m_pend = -1;
        end else if (m_rown) begin
            e_cmd = rfsh_cmd; e_a = rfsh_a; e_ba = '0;
            if (rfshing) m_rseen = 1;
            else if (m_rseen) begin m_rown = 0; m_hold = RFSH_WAIT; end
            else if (m_rage >= 3) m_rown = 0;
            else m_rage++;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (rfsh_br) begin
            if (bank_idle == 4'hF) begin
                e_rbg = 1; m_rown = 1; m_rseen = 0; m_rage = 0;
            end
        end else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (!found && bank_br[j]) begin
                    found = 1; e_bbg[j] = 1'b1; m_pend = j;
                end
            end
        end
    endfunction

    // ---------------- stimulus side ----------------
    logic [3:0] req = '0;
    int rf_len = 0, rf_left = 0;

    // One clock: predict, clock, compare, then react to the grants seen.
    task automatic cyc();
        bank_br = req;
        model_step();
        @(posedge clk); #1;
        chk("bank_bg",   32'(bank_bg),   32'(e_bbg));
        chk("rfsh_bg",   32'(rfsh_bg),   32'(e_rbg));
        chk("sdram_cmd", 32'(sdram_cmd), 32'(e_cmd));
        chk("sdram_a",   32'(sdram_a),   32'(e_a));
        chk("sdram_ba",  32'(sdram_ba),  32'(e_ba));
        req = req & ~bank_bg;
        if (rfsh_bg) begin rfsh_br = 0; rf_left = rf_len; end
        rfshing = (rf_left > 0);
        if (rf_left > 0) begin
            rfsh_cmd = (rf_left == rf_len) ? PRE : REF;
            rf_left--;
        end else begin
            rfsh_cmd = NOP;
        end
        rfsh_a = 13'($urandom);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_cmd",  32'(sdram_cmd), 32'(NOP));
        chk("rst_bbg",  32'(bank_bg),   32'h0);
        chk("rst_rbg",  32'(rfsh_bg),   32'h0);
        chk("rst_a",    32'(sdram_a),   32'h0);
        chk("rst_ba",   32'(sdram_ba),  32'h0);
        @(posedge clk); #1; rst = 0;

        // round-robin with all four requesting continuously
        bank_cmd = 16'h5434; bank_a = 52'h0123456789ABC;
        for (int i = 0; i < 10; i++) begin req = 4'hF; cyc(); end
        req = '0; cyc(); cyc();

        // address mux through bank 2
        bank_a[38:26] = 13'h1ABC; bank_cmd[11:8] = 4'b0011;
        req = 4'b0100; for (int i = 0; i < 4; i++) cyc();

        // refresh held off by a busy bank, then released
        rfsh_br = 1; bank_idle = 4'b1101; rf_len = 6;
        for (int i = 0; i < 4; i++) cyc();
        bank_idle = 4'hF; req = 4'b0001;
        for (int i = 0; i < 14; i++) cyc();

        // watchdog: granted refresh that never raises rfshing
        rfsh_br = 1; rf_len = 0; req = 4'b0100;
        for (int i = 0; i < 10; i++) cyc();

        // async reset in the middle of a bank cycle
        req = 4'b0010; cyc();
        #2 rst = 1; #1;
        chk("mid_cmd", 32'(sdram_cmd), 32'(NOP));
        chk("mid_bbg", 32'(bank_bg),   32'h0);
        chk("mid_rbg", 32'(rfsh_bg),   32'h0);
        chk("mid_a",   32'(sdram_a),   32'h0);
        chk("mid_ba",  32'(sdram_ba),  32'h0);
        model_reset(); req = '0; bank_br = '0; rfsh_br = 0;
        rfshing = 0; rf_left = 0; rfsh_cmd = NOP;
        @(posedge clk); #1;
        chk("mid_hold", 32'(sdram_cmd), 32'(NOP));
        rst = 0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!rfsh_br && rf_left == 0 && $urandom_range(0, 39) == 0) begin
                rfsh_br = 1; rf_len = $urandom_range(0, 6);
            end
            req = req | (4'($urandom) & 4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 15) == 0) req = req & 4'($urandom);
            bank_idle = 4'($urandom) | 4'($urandom);
            bank_cmd  = 16'($urandom);
            bank_a    = 52'({$urandom(), $urandom()});
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
